multi_cycle_mips_control: RTL
=============================

# multi_cycle_mips_control

Multi-cycle control sequencer for the MIPS core. It replaces per-instruction single-cycle decode with a state machine that steps one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and writeback. It sits beside the datapath (PC, IR, register file, ALU, ALUOut/MDR registers) and talks to memory through a req/ready handshake. It supports the core ISA: add, and, or, sub, sll, lw, sw, addi, andi, beq, j.

## Interface
No parameters.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- instruction  in  32  IR contents; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- alu_zero  in  1  ALU result == 0.
- state  out  4  current state, for debug.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; valid only with mem_req.
- mem_addr_source  out  1  0 = PC, 1 = ALUOut.
- ir_write, pc_write, reg_write  out  1 each  register enables.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 {PC[31:28], jump_imm, 2'b00}.
- reg_dst  out  1  0 = rt [20:16], 1 = rd [15:11].
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- alu_a_source  out  2  00 PC, 01 rs [25:21], 10 rt [20:16] (sll).
- alu_b_source  out  3  000 reg2, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 shamt [10:6].
- alu_ctrl  out  3  010 add, 000 and, 001 or, 110 sub, 011 sll.
- instr_retired  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_instr  out  1  one-cycle pulse in DECODE for an unsupported opcode or funct.

## Operation
- States (4-bit encoding): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11.
- Defaults are 0 in every state, except alu_ctrl=010 (add).
- **FETCH**
  - mem_req=1, mem_addr_source=0, alu_a=PC, alu_b=4.
  - When mem_ready=1 (Mealy): ir_write=1, pc_write=1, pc_source=00, then go to DECODE.
  - Otherwise hold in FETCH.
- **DECODE**
  - alu_a=PC, alu_b=imm<<2, add. This precomputes the branch target into ALUOut.
  - Dispatch on opcode:
    - lw (100011) / sw (101011) → MEM_ADDR.
    - 000000 with funct in {100000, 100100, 100101, 100010, 000000} → R_EXEC.
    - addi (001000) / andi (001100) → I_EXEC.
    - beq (000100) → BRANCH.
    - j (000010) → JUMP.
    - Anything else: illegal_instr=1, instr_retired=1, → FETCH. PC is already advanced, so the instruction acts as a nop.
- **MEM_ADDR**: alu_a=rs, alu_b=imm, add. lw → MEM_READ, sw → MEM_WRITE.
- **MEM_READ**: mem_req=1, mem_addr_source=1. On mem_ready → MEM_WB (MDR captures data externally).
- **MEM_WB**: reg_write=1, reg_dst=0, mem_to_reg=1, instr_retired=1, → FETCH.
- **MEM_WRITE**: mem_req=1, mem_we=1, mem_addr_source=1. On mem_ready: instr_retired=1, → FETCH.
- **R_EXEC**: alu_a=rs, alu_b=reg2, alu_ctrl from funct. sll instead uses alu_a=rt, alu_b=shamt, alu_ctrl=011. → R_WB.
- **R_WB**: reg_write=1, reg_dst=1, mem_to_reg=0, instr_retired=1, → FETCH.
- **I_EXEC**: alu_a=rs, alu_b=imm. addi → 010, andi → 000. → I_WB.
- **I_WB**: reg_write=1, reg_dst=0, mem_to_reg=0, instr_retired=1, → FETCH.
- **BRANCH**: alu_a=rs, alu_b=reg2, sub, pc_source=01, pc_write=alu_zero, instr_retired=1, → FETCH.
- **JUMP**: pc_source=10, pc_write=1, instr_retired=1, → FETCH.

## Timing
- While rst_n=0:
  - state=FETCH.
  - All outputs forced to 0; alu_ctrl also 0.
  - mem_req rises in the first cycle after release.
- Latency in cycles with zero-wait memory (mem_ready high on the first request cycle):
  - lw 5.
  - R-type, addi, andi, sw 4.
  - beq, j 3.
  - Each cycle with mem_ready low during a request adds one cycle.
- Memory handshake:
  - mem_req, mem_we and mem_addr_source stay stable from request until the mem_ready cycle.
  - mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
  - A request never drops without mem_ready, except on reset.
- ir_write and pc_write in FETCH are combinational on mem_ready in the same cycle.
- Reset mid-access drops mem_req asynchronously and restarts at FETCH. No partial write is retried.

## Test plan
- Reset, then release with mem_ready tied to 1 and IR=add (0x012A4020) → states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_retired pulses once.
- lw (0x8D280004) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ → 10 cycles total; mem_req held throughout each wait; ir_write high only in the mem_ready cycle.
- beq (0x11090003):
  - alu_zero=1 in BRANCH → pc_write=1, pc_source=01.
  - alu_zero=0 → pc_write=0.
  - Both cases take 3 cycles.
- sll (0x00094080) → R_EXEC drives alu_a=10, alu_b=100, alu_ctrl=011; j (0x08000010) → JUMP with pc_source=10, pc_write=1.
- Opcode 0x3F → illegal_instr and instr_retired pulse in DECODE; next state is FETCH; no reg_write or mem_req.
- rst_n asserted mid-MEM_WRITE → mem_we/mem_req drop immediately; after release, FETCH with mem_addr_source=0.

Source files
------------

// File: rtl/multi_cycle_mips_control.sv
// Multi-cycle MIPS control sequencer: steps a shared ALU and a unified memory
// through fetch/decode/execute/memory/writeback for the core integer ISA.
module multi_cycle_mips_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [3:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_source,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  pc_source,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  alu_a_source,
    output logic [2:0]  alu_b_source,
    output logic [2:0]  alu_ctrl,
    output logic        instr_retired,
    output logic        illegal_instr
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b011;

    state_t     state_q, state_d;
    logic [5:0] opcode, funct;
    logic       funct_ok;
    logic       unused_instr_bits;

    assign opcode            = instruction[31:26];
    assign funct             = instruction[5:0];
    assign unused_instr_bits = ^instruction[25:6];
    assign state             = state_q;
    assign funct_ok = (funct == FN_ADD) || (funct == FN_AND) || (funct == FN_OR) ||
                      (funct == FN_SUB) || (funct == FN_SLL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr_source = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        reg_write       = 1'b0;
        pc_source       = 2'b00;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        alu_a_source    = 2'b00;
        alu_b_source    = 3'b000;
        alu_ctrl        = ALU_ADD;
        instr_retired   = 1'b0;
        illegal_instr   = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                alu_b_source = 3'b001;
                // IR/PC capture is Mealy on mem_ready so zero-wait fetch takes one cycle
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding
                alu_b_source = 3'b011;
                if (opcode == OP_LW || opcode == OP_SW)       state_d = S_MEM_ADDR;
                else if (opcode == OP_RTYPE && funct_ok)      state_d = S_R_EXEC;
                else if (opcode == OP_ADDI || opcode == OP_ANDI) state_d = S_I_EXEC;
                else if (opcode == OP_BEQ)                    state_d = S_BRANCH;
                else if (opcode == OP_J)                      state_d = S_JUMP;
                else begin
                    illegal_instr = 1'b1;
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                alu_a_source = 2'b01;
                alu_b_source = 3'b010;
                state_d      = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req         = 1'b1;
                mem_addr_source = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write     = 1'b1;
                mem_to_reg    = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req         = 1'b1;
                mem_we          = 1'b1;
                mem_addr_source = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_a_source = 2'b01;
                case (funct)
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_SLL: begin
                        alu_a_source = 2'b10;
                        alu_b_source = 3'b100;
                        alu_ctrl     = ALU_SLL;
                    end
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = S_R_WB;
            end
            S_R_WB: begin
                reg_write     = 1'b1;
                reg_dst       = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_I_EXEC: begin
                alu_a_source = 2'b01;
                alu_b_source = 3'b010;
                alu_ctrl     = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
                state_d      = S_I_WB;
            end
            S_I_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_a_source  = 2'b01;
                alu_ctrl      = ALU_SUB;
                pc_source     = 2'b01;
                pc_write      = alu_zero;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_source     = 2'b10;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset gates every output combinationally so an in-flight request drops at once
        if (!rst_n) begin
            mem_req         = 1'b0;
            mem_we          = 1'b0;
            mem_addr_source = 1'b0;
            ir_write        = 1'b0;
            pc_write        = 1'b0;
            reg_write       = 1'b0;
            pc_source       = 2'b00;
            reg_dst         = 1'b0;
            mem_to_reg      = 1'b0;
            alu_a_source    = 2'b00;
            alu_b_source    = 3'b000;
            alu_ctrl        = 3'b000;
            instr_retired   = 1'b0;
            illegal_instr   = 1'b0;
        end
    end

endmodule
